// File: rtl/sdr_host_seq_pkg.sv
// Shared encodings for the SDR host sequencer: controller commands, FSM states,
// beat-timer phases and the init-step command table.
package sdr_host_seq_pkg;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_READA     = 3'd1,
    CMD_WRITEA    = 3'd2,
    CMD_PRECHARGE = 3'd4,
    CMD_LOAD_MODE = 3'd5,
    CMD_LOAD_REG1 = 3'd6,
    CMD_LOAD_REG2 = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_CMD,
    ST_INIT_GAP,
    ST_IDLE,
    ST_ISSUE,
    ST_WLAT,
    ST_WDATA,
    ST_RLAT,
    ST_RDATA
  } state_e;

  typedef enum logic [1:0] {
    TMR_IDLE,
    TMR_LAT,
    TMR_BEAT
  } tmr_phase_e;

  localparam int LAT_W  = 4;
  localparam int BEAT_W = 3;

  function automatic cmd_e init_step_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return CMD_LOAD_REG1;
      2'd1:    return CMD_LOAD_REG2;
      2'd2:    return CMD_PRECHARGE;
      default: return CMD_LOAD_MODE;
    endcase
  endfunction

endpackage

// File: rtl/sdr_beat_timer.sv
// Latency counter followed by a beat counter: after start, waits `delay` cycles
// (counted from the start cycle) and then strobes `beat` for BURST cycles.
module sdr_beat_timer
  import sdr_host_seq_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LAT_W-1:0] delay,
  output logic             lat_done,
  output logic             beat,
  output logic             last
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

  tmr_phase_e        phase_q, phase_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  assign lat_done = (phase_q == TMR_LAT) && (lat_q == delay - LAT_W'(1));
  assign beat     = (phase_q == TMR_BEAT);
  // Terminal compare on the 3-bit count keeps BURST=8 from wrapping into a 9th beat.
  assign last     = beat && (beat_q == LAST_BEAT);

  always_comb begin
    phase_d = phase_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    case (phase_q)
      TMR_IDLE: begin
        if (start) begin
          lat_d   = LAT_W'(1);
          beat_d  = '0;
          phase_d = (delay <= LAT_W'(1)) ? TMR_BEAT : TMR_LAT;
        end
      end
      TMR_LAT: begin
        if (lat_done) begin
          phase_d = TMR_BEAT;
          beat_d  = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      TMR_BEAT: begin
        if (last) begin
          phase_d = TMR_IDLE;
          lat_d   = '0;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: phase_d = TMR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= TMR_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
    end else begin
      phase_q <= phase_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: rtl/sdr_host_seq.sv
// Host-side sequencer for the SDR SDRAM controller: runs the register/mode init
// sequence, then issues read/write bursts and paces their data beats.
module sdr_host_seq
  import sdr_host_seq_pkg::*;
#(
  parameter int               ASIZE     = 23,
  parameter int               DSIZE     = 32,
  parameter int               BURST     = 4,
  parameter int               RD_LAT    = 7,
  parameter int               WR_LAT    = 2,
  parameter int               INIT_WAIT = 100,
  parameter logic [ASIZE-1:0] REG1_VAL  = 'h000312,
  parameter logic [ASIZE-1:0] REG2_VAL  = 'h000600,
  parameter logic [ASIZE-1:0] MODE_VAL  = 'h000032,
  parameter int               ACK_TMO   = 1023
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic               REQ_WRITE,
  input  logic [ASIZE-1:0]   REQ_ADDR,
  output logic               WR_REQ,
  input  logic [DSIZE-1:0]   WR_DATA,
  input  logic [DSIZE/8-1:0] WR_DM,
  output logic               RD_VALID,
  output logic [DSIZE-1:0]   RD_DATA,
  output logic               INIT_DONE,
  output logic               ERR,
  output logic [2:0]         CMD,
  output logic [ASIZE-1:0]   ADDR,
  input  logic               CMDACK,
  output logic [DSIZE-1:0]   DATAIN,
  output logic [DSIZE/8-1:0] DM,
  input  logic [DSIZE-1:0]   DATAOUT
);

  localparam int DM_W    = DSIZE / 8;
  localparam int CNT_MAX = (INIT_WAIT > ACK_TMO) ? INIT_WAIT : ACK_TMO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic [ASIZE-1:0]   addr_q, addr_d;
  logic [DSIZE-1:0]   datain_q, datain_d;
  logic [DM_W-1:0]    dm_q, dm_d;
  logic [DSIZE-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               init_done_q, init_done_d;
  logic               err_q, err_d;
  logic               is_wr_q, is_wr_d;
  logic [1:0]         step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               tmr_start, tmr_lat_done, tmr_beat, tmr_last;
  logic [LAT_W-1:0]   tmr_delay;

  function automatic logic [ASIZE-1:0] init_step_addr(input logic [1:0] step);
    case (step)
      2'd0:    return REG1_VAL;
      2'd1:    return REG2_VAL;
      2'd2:    return '0;
      default: return MODE_VAL;
    endcase
  endfunction

  assign tmr_delay = is_wr_q ? LAT_W'(WR_LAT) : LAT_W'(RD_LAT);

  sdr_beat_timer #(.BURST(BURST)) u_timer (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .start    (tmr_start),
    .delay    (tmr_delay),
    .lat_done (tmr_lat_done),
    .beat     (tmr_beat),
    .last     (tmr_last)
  );

  assign REQ_READY = (state_q == ST_IDLE) && init_done_q && !err_q;
  assign WR_REQ    = (state_q == ST_WDATA) && tmr_beat;
  assign CMD       = cmd_q;
  assign ADDR      = addr_q;
  assign DATAIN    = datain_q;
  assign DM        = dm_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_data_q;
  assign INIT_DONE = init_done_q;
  assign ERR       = err_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    datain_d    = '0;
    dm_d        = '0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    init_done_d = init_done_q;
    err_d       = err_q;
    is_wr_d     = is_wr_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    tmr_start   = 1'b0;
    case (state_q)
      ST_INIT_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(INIT_WAIT - 1)) begin
          state_d = ST_INIT_CMD;
          step_d  = 2'd0;
          cmd_d   = init_step_cmd(2'd0);
          addr_d  = init_step_addr(2'd0);
          cnt_d   = '0;
        end
      end
      ST_INIT_CMD, ST_ISSUE: begin
        if (CMDACK) begin
          cmd_d = CMD_NOP;
          cnt_d = '0;
          if (state_q == ST_INIT_CMD) begin
            if (step_q == 2'd3) begin
              init_done_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d = ST_INIT_GAP;
            end
          end else begin
            tmr_start = 1'b1;
            if (is_wr_q) state_d = (WR_LAT <= 1) ? ST_WDATA : ST_WLAT;
            else         state_d = (RD_LAT <= 1) ? ST_RDATA : ST_RLAT;
          end
        end else if (cnt_q == CNT_W'(ACK_TMO - 1)) begin
          // Give up on the pending command; only reset recovers from here.
          err_d   = 1'b1;
          cmd_d   = CMD_NOP;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_INIT_GAP: begin
        step_d  = step_q + 2'd1;
        cmd_d   = init_step_cmd(step_q + 2'd1);
        addr_d  = init_step_addr(step_q + 2'd1);
        state_d = ST_INIT_CMD;
      end
      ST_IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          addr_d  = REQ_ADDR;
          cmd_d   = REQ_WRITE ? CMD_WRITEA : CMD_READA;
          is_wr_d = REQ_WRITE;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_WLAT: if (tmr_lat_done) state_d = ST_WDATA;
      ST_WDATA: begin
        if (tmr_beat) begin
          datain_d = WR_DATA;
          dm_d     = WR_DM;
        end
        if (tmr_last) state_d = ST_IDLE;
      end
      ST_RLAT: if (tmr_lat_done) state_d = ST_RDATA;
      ST_RDATA: begin
        if (tmr_beat) begin
          rd_data_d  = DATAOUT;
          rd_valid_d = 1'b1;
        end
        if (tmr_last) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_INIT_WAIT;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      datain_q    <= '0;
      dm_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      is_wr_q     <= 1'b0;
      step_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      datain_q    <= datain_d;
      dm_q        <= dm_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      is_wr_q     <= is_wr_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
